// File: rtl/alu_div_seq.sv
// Sequential non-restoring divider: one quotient bit per clock, signed or unsigned,
// start/busy/done handshake, divide-by-zero and signed-overflow flags.
module alu_div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  // Handshake: start is taken only in IDLE; busy covers ITER and FIX;
  // done pulses for one cycle and results/flags then hold until the next accept.
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;
  state_t state;

  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] qr;
  logic [WIDTH-1:0] m;
  logic [CW-1:0]    cnt;
  logic             q_neg;
  logic             r_neg;
  logic             ovf_pend;
  logic             dbz_pend;

  logic             dvd_neg;
  logic             dvs_neg;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH:0]   acc_sh;
  logic [WIDTH:0]   acc_step;
  logic [WIDTH:0]   acc_fix;
  logic [WIDTH-1:0] rem_mag;

  // MIN's magnitude 2^(WIDTH-1) is a valid unsigned value, so no special path is needed.
  always_comb begin
    dvd_neg  = is_signed & dividend[WIDTH-1];
    dvs_neg  = is_signed & divisor[WIDTH-1];
    dvd_mag  = dvd_neg ? -dividend : dividend;
    dvs_mag  = dvs_neg ? -divisor : divisor;
    acc_sh   = {acc[WIDTH-1:0], qr[WIDTH-1]};
    acc_step = acc[WIDTH] ? acc_sh + {1'b0, m} : acc_sh - {1'b0, m};
    acc_fix  = acc[WIDTH] ? acc + {1'b0, m} : acc;
    rem_mag  = acc_fix[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state       <= IDLE;
      acc         <= '0;
      qr          <= '0;
      m           <= '0;
      cnt         <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      ovf_pend    <= 1'b0;
      dbz_pend    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            q_neg       <= dvd_neg ^ dvs_neg;
            r_neg       <= dvd_neg;
            ovf_pend    <= is_signed && (dividend == MIN_VAL) && (divisor == '1);
            acc         <= '0;
            m           <= dvs_mag;
            cnt         <= CW'(WIDTH);
            if (divisor == '0) begin
              qr       <= dividend;
              dbz_pend <= 1'b1;
              state    <= DONE;
            end else begin
              qr       <= dvd_mag;
              dbz_pend <= 1'b0;
              busy     <= 1'b1;
              state    <= ITER;
            end
          end
        end
        ITER: begin
          acc <= acc_step;
          qr  <= {qr[WIDTH-2:0], ~acc_step[WIDTH]};
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= FIX;
        end
        FIX: begin
          quotient  <= q_neg ? -qr : qr;
          remainder <= r_neg ? -rem_mag : rem_mag;
          overflow  <= ovf_pend;
          busy      <= 1'b0;
          done      <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          // A divide-by-zero spends one extra cycle here to raise its done pulse.
          if (dbz_pend) begin
            quotient    <= '1;
            remainder   <= qr;
            div_by_zero <= 1'b1;
            done        <= 1'b1;
            dbz_pend    <= 1'b0;
          end else begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
